// File: rtl/master_audio_gain_pipe.sv
// Per-channel fixed-point gain pipeline with valid/ready handshake.
// Define MASTER_AUDIO_GAIN_SAT_EN for clamping and the sticky sat_flag.
module master_audio_gain_pipe #(
  parameter int DIN_W      = 24,
  parameter int GAIN_W     = 10,
  parameter int FRAC_W     = 9,
  parameter int DOUT_W     = 24,
  parameter int NUM_STAGE  = 3,
  parameter int CHANNELS   = 2,
  parameter int GAIN_RESET = 512,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [DIN_W-1:0]  s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CH_W-1:0]   m_ch,
  output logic [DOUT_W-1:0] m_data,
  input  logic              gain_we,
  input  logic [CH_W-1:0]   gain_ch,
  input  logic [GAIN_W-1:0] gain_data,
  output logic              sat_flag,
  input  logic              sat_clr
);

  localparam int P_W = DIN_W + GAIN_W + 1;
  localparam int PS  = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam logic [P_W-1:0] HALF =
    P_W'(64'(1) << (FRAC_W - 1));
  localparam logic [DOUT_W-1:0] MAXV =
    {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] MINV =
    {1'b1, {(DOUT_W-1){1'b0}}};

  logic [GAIN_W-1:0] gain [CHANNELS];
  logic              en;
  logic [GAIN_W-1:0] g_sel;
  logic [P_W-1:0]    a_x;
  logic [P_W-1:0]    g_x;
  logic [P_W-1:0]    prod;

  logic              fin_v;
  logic [CH_W-1:0]   fin_ch;
  logic [P_W-1:0]    fin_p;
  logic [P_W-1:0]    sum;
  logic [P_W-1:0]    sh;
  logic              ovf;
  logic [DOUT_W-1:0] res;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  // Gain lookup; unknown channels scale by zero.
  always_comb begin
    g_sel = '0;
    if (int'(s_ch) < CHANNELS)
      g_sel = gain[s_ch];
  end

  assign a_x  = {{(P_W-DIN_W){s_data[DIN_W-1]}}, s_data};
  assign g_x  = {{(P_W-GAIN_W){1'b0}}, g_sel};
  assign prod = P_W'($signed(a_x) * $signed(g_x));

  // Gain table: writes ignore backpressure and bad channels.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < CHANNELS; i++)
        gain[i] <= GAIN_W'(GAIN_RESET);
    end else if (gain_we && int'(gain_ch) < CHANNELS) begin
      gain[gain_ch] <= gain_data;
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign fin_v  = s_valid;
      assign fin_ch = s_ch;
      assign fin_p  = prod;
    end else begin : g_pipe
      logic [PS-1:0]   pv;
      logic [CH_W-1:0] pc [PS];
      logic [P_W-1:0]  pd [PS];

      // Product delay line; all stages move together on en.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          pv <= '0;
          for (int i = 0; i < PS; i++) begin
            pc[i] <= '0;
            pd[i] <= '0;
          end
        end else if (en) begin
          pv[0] <= s_valid;
          pc[0] <= s_ch;
          pd[0] <= prod;
          for (int i = 1; i < PS; i++) begin
            pv[i] <= pv[i-1];
            pc[i] <= pc[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign fin_v  = pv[PS-1];
      assign fin_ch = pc[PS-1];
      assign fin_p  = pd[PS-1];
    end
  endgenerate

  assign sum = fin_p + HALF;
  assign sh  = P_W'($signed(sum) >>> FRAC_W);
  assign ovf = (|sh[P_W-1:DOUT_W-1]) &&
               !(&sh[P_W-1:DOUT_W-1]);

`ifdef MASTER_AUDIO_GAIN_SAT_EN
  logic o_sat;

  always_comb begin
    res = sh[DOUT_W-1:0];
    if (ovf)
      res = sh[P_W-1] ? MINV : MAXV;
  end

  // Output register with clamp marker for the sticky flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_data  <= '0;
      o_sat   <= 1'b0;
    end else if (en) begin
      m_valid <= fin_v;
      m_ch    <= fin_ch;
      m_data  <= res;
      o_sat   <= fin_v && ovf;
    end
  end

  // Sticky flag: a clamped transfer beats a clear.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      sat_flag <= 1'b0;
    else if (m_valid && m_ready && o_sat)
      sat_flag <= 1'b1;
    else if (sat_clr)
      sat_flag <= 1'b0;
  end
`else
  logic unused_bits;

  assign unused_bits = ^{ovf, sh[P_W-1:DOUT_W], sat_clr,
                         MAXV, MINV};
  assign res      = sh[DOUT_W-1:0];
  assign sat_flag = 1'b0;

  // Output register; results wrap to DOUT_W bits.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_data  <= '0;
    end else if (en) begin
      m_valid <= fin_v;
      m_ch    <= fin_ch;
      m_data  <= res;
    end
  end
`endif

endmodule

// File: tb/tb_master_audio_gain_pipe.sv
// Scoreboard bench for master_audio_gain_pipe (default parameters).
// Expected results are hand-computed; the monitor pops on transfers.
module tb_master_audio_gain_pipe;

  logic               clk = 1'b0;
  logic               ap_rst;
  logic               s_valid;
  logic               s_ready;
  logic [0:0]         s_ch;
  logic signed [23:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic [0:0]         m_ch;
  logic signed [23:0] m_data;
  logic               gain_we;
  logic [0:0]         gain_ch;
  logic [9:0]         gain_data;
  logic               sat_flag;
  logic               sat_clr;

  int checks = 0;
  int errors = 0;

  logic signed [23:0] q_d [$];
  logic [0:0]         q_ch [$];

`ifdef MASTER_AUDIO_GAIN_SAT_EN
  localparam int E_POS = 8388607;
  localparam int E_NEG = -8388608;
  localparam int E_SAT = 1;
`else
  localparam int E_POS = -16386;
  localparam int E_NEG = 16384;
  localparam int E_SAT = 0;
`endif

  master_audio_gain_pipe dut (
    .ap_clk    (clk),
    .ap_rst    (ap_rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_ch      (s_ch),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_ch      (m_ch),
    .m_data    (m_data),
    .gain_we   (gain_we),
    .gain_ch   (gain_ch),
    .gain_data (gain_data),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [0:0] ch, input int data,
                      input int expd, input bit track);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_ch    = ch;
    s_data  = 24'(data);
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0 expected 1");
    end
    @(posedge clk);
    if (track) begin
      q_d.push_back(24'(expd));
      q_ch.push_back(ch);
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic set_gain(input logic [0:0] ch, input int g);
    gain_we   = 1'b1;
    gain_ch   = ch;
    gain_data = 10'(g);
    @(posedge clk);
    #1;
    gain_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q_d.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q_d.size(), 0);
  endtask

  // Monitor: compare on transfers, check hold while stalled.
  initial begin
    bit                 prev_stall;
    logic signed [23:0] prev_d;
    logic [0:0]         prev_ch;
    logic signed [23:0] ed;
    logic [0:0]         ec;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_ch    = '0;
    forever begin
      @(negedge clk);
      if (ap_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_d);
          chk("hold_ch", m_ch, prev_ch);
        end
        if (m_valid && m_ready) begin
          if (q_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0d expected none",
                     m_data);
          end else begin
            ed = q_d.pop_front();
            ec = q_ch.pop_front();
            chk("out_data", m_data, ed);
            chk("out_ch", m_ch, ec);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_d     = m_data;
        prev_ch    = m_ch;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sd [8];
    int se [8];
    bit rp [4];
    sd = '{10, 20, -7, 5, 100, -5, 12345, 8};
    se = '{10, 10, -7, 3, 100, -2, 12345, 4};
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};

    ap_rst    = 1'b1;
    s_valid   = 1'b0;
    s_ch      = '0;
    s_data    = '0;
    m_ready   = 1'b1;
    gain_we   = 1'b0;
    gain_ch   = '0;
    gain_data = '0;
    sat_clr   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_ch", m_ch, 0);
    chk("rst_sat_flag", sat_flag, 0);
    ap_rst = 1'b0;
    chk("rst_s_ready", s_ready, 1);

    send(1'b0, 1000, 1000, 1'b1);
    lat = 1;
    while (!m_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    wait_drain();

    set_gain(1'b1, 256);
    send(1'b1, 3, 2, 1'b1);
    send(1'b1, -3, -1, 1'b1);
    send(1'b1, 1, 1, 1'b1);
    send(1'b1, -1, 0, 1'b1);
    wait_drain();

    set_gain(1'b0, 1023);
    send(1'b0, 8388607, E_POS, 1'b1);
    wait_drain();
    chk("sat_set", sat_flag, E_SAT);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_clr", sat_flag, 0);
    send(1'b0, -8388608, E_NEG, 1'b1);
    wait_drain();
    chk("sat_set_wins", sat_flag, E_SAT);
    sat_clr = 1'b0;

    set_gain(1'b0, 512);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          m_ready = rp[i % 4];
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++)
          send(1'(i % 2), sd[i], se[i], 1'b1);
      end
    join
    wait_drain();

    gain_we   = 1'b1;
    gain_ch   = 1'b0;
    gain_data = 10'd0;
    send(1'b0, 500, 500, 1'b1);
    gain_we = 1'b0;
    send(1'b0, 500, 0, 1'b1);
    wait_drain();

    m_ready = 1'b0;
    send(1'b0, 11, 0, 1'b0);
    send(1'b1, 22, 0, 1'b0);
    send(1'b0, 33, 0, 1'b0);
    ap_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ap_rst = 1'b0;
    chk("post_rst_s_ready", s_ready, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dropped", m_valid, 0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 7, 7, 1'b1);
    send(1'b1, 7, 7, 1'b1);
    wait_drain();

    repeat (5) @(posedge clk);
    chk("queue_empty", q_d.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/master_audio_gain_pipe.md
MASTER_AUDIO_GAIN_PIPE -- requirements
Module: master_audio_gain_pipe

Interface
REQ-001 SHALL have parameter DIN_W, default 24, signed sample width.
REQ-002 SHALL have parameter GAIN_W, default 10, unsigned gain width.
REQ-003 SHALL have parameter FRAC_W, default 9, gain fractional bits, so 512 = 1.0.
REQ-004 SHALL have parameter DOUT_W, default 24, signed result width.
REQ-005 SHALL have parameter NUM_STAGE, default 3, range 1..4, pipeline depth.
REQ-006 SHALL have parameter CHANNELS, default 2, range 1..16; CH_W = max(1, clog2(CHANNELS)).
REQ-007 SHALL have parameter GAIN_RESET, default 512, reset gain of every channel.
REQ-008 ap_clk  in  1  sole clock; all logic on its rising edge.
REQ-009 ap_rst  in  1  reset; synchronous, active-high.
REQ-010 s_valid / s_ready  in / out  1 / 1  input sample handshake.
REQ-011 s_ch  in  CH_W  channel tag of the input sample.
REQ-012 s_data  in  DIN_W  signed input sample.
REQ-013 m_valid / m_ready  out / in  1 / 1  output handshake.
REQ-014 m_ch  out  CH_W  channel tag carried with the result.
REQ-015 m_data  out  DOUT_W  signed scaled result.
REQ-016 gain_we / gain_ch / gain_data  in  1 / CH_W / GAIN_W  per-channel gain write port.
REQ-017 sat_flag / sat_clr  out / in  1 / 1  sticky overflow flag and its clear (behaviour per REQ-033).

Function
REQ-018 SHALL accept a sample when s_valid && s_ready are high at a clock edge.
REQ-019 SHALL compute the product as signed s_data times zero-extended unsigned gain[s_ch], using DIN_W+GAIN_W+1 bits with no loss.
REQ-020 SHALL round half toward +infinity: add 2^(FRAC_W-1), then arithmetic-shift right by FRAC_W.
REQ-021 SHALL reduce the shifted value to DOUT_W bits as set by the configuration (REQ-032/033).
REQ-022 Pipeline enable SHALL be en = !m_valid || m_ready, and s_ready SHALL equal en.
REQ-023 All NUM_STAGE stages SHALL advance together when en is high and hold when it is low; bubbles are not collapsed.
REQ-024 Latency SHALL be NUM_STAGE cycles from acceptance to m_valid with no backpressure; throughput SHALL be 1 sample per cycle.
REQ-025 m_data and m_ch SHALL stay stable while m_valid && !m_ready.
REQ-026 The gain SHALL be sampled at the acceptance edge; a gain_we on the same edge SHALL affect only samples accepted on later edges.
REQ-027 A gain_we with gain_ch >= CHANNELS SHALL be ignored.
REQ-028 An input sample with s_ch >= CHANNELS SHALL use gain 0, and its tag SHALL be passed through unchanged.
REQ-029 gain_we SHALL take effect regardless of backpressure.

Reset
REQ-030 While ap_rst is high, the block SHALL clear all stage valids, drive m_valid=0, m_data=0, m_ch=0, sat_flag=0, and set every gain to GAIN_RESET.
REQ-031 Reset mid-stream SHALL drop in-flight samples; s_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-032 With MASTER_AUDIO_GAIN_SAT_EN defined, out-of-range results SHALL clamp to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
REQ-033 With MASTER_AUDIO_GAIN_SAT_EN defined, sat_flag SHALL set on any clamped output transfer and clear on sat_clr; a set and a clear in the same cycle SHALL leave the flag set.
REQ-034 Without MASTER_AUDIO_GAIN_SAT_EN, results SHALL wrap to the low DOUT_W bits, sat_flag SHALL be tied 0, and sat_clr SHALL be ignored.

Verification (defaults)
REQ-035 Reset, then s_data=1000 on ch0 with m_ready=1 -> m_data=1000 and m_ch=0 exactly 3 cycles after acceptance.
REQ-036 gain[1]=256; s_data=3 then -3 on ch1 -> m_data=2, then -1.
REQ-037 gain[0]=1023, s_data=8388607 -> with SAT_EN, m_data=8388607 and sat_flag=1; without SAT_EN, m_data=-16386.
REQ-038 Stream 8 samples while m_ready toggles 1,0,0,1 -> no loss or duplication, order kept, m_data held while stalled.
REQ-039 gain_we to ch0 (value 0) on the same edge as a ch0 sample of 500 -> that sample yields 500; the next ch0 sample yields 0.
REQ-040 Assert ap_rst with 3 samples in flight -> no m_valid afterwards, gains read back 512 (s_data=7 -> 7).
